// File: rtl/send_pkt_sched.sv
// Fixed-priority send-packet scheduler with per-source starvation promotion.
// One registered output slot; sources are granted only when the slot can take a packet.
module send_pkt_sched #(
    parameter int unsigned NUM_SRCS     = 3,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRCS-1:0]          src_val,
    input  logic [NUM_SRCS*DATA_W-1:0]   src_data,
    output logic [NUM_SRCS-1:0]          src_rdy,
    output logic                         dst_val,
    output logic [DATA_W-1:0]            dst_data,
    input  logic                         dst_rdy,
    output logic [NUM_SRCS-1:0]          urgent
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic                  in_rdy_c;
    logic                  accept_c;
    logic [NUM_SRCS-1:0]   urg_val_c;
    logic [NUM_SRCS-1:0]   pick_vec_c;
    logic [NUM_SRCS-1:0]   grant_c;
    logic [DATA_W-1:0]     sel_data_c;
    logic [CNT_W-1:0]      cnt_q [NUM_SRCS];
    logic [CNT_W-1:0]      cnt_d [NUM_SRCS];

    assign in_rdy_c   = !dst_val || dst_rdy;
    assign urg_val_c  = src_val & urgent;
    assign pick_vec_c = (|urg_val_c) ? urg_val_c : src_val;

    // Lowest set bit of the candidate vector wins; scanning downward lets it overwrite higher ones.
    always_comb begin
        grant_c    = '0;
        sel_data_c = '0;
        for (int i = NUM_SRCS - 1; i >= 0; i--) begin
            if (pick_vec_c[i]) begin
                grant_c    = '0;
                grant_c[i] = 1'b1;
                sel_data_c = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept_c = rst && in_rdy_c && (|src_val);
    assign src_rdy  = grant_c & {NUM_SRCS{in_rdy_c && rst}};

    // Wait counters freeze while the output slot is stalled.
    always_comb begin
        for (int i = 0; i < NUM_SRCS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (in_rdy_c) begin
                if (!src_val[i] || grant_c[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dst_val  <= 1'b0;
            dst_data <= '0;
            urgent   <= '0;
            for (int i = 0; i < NUM_SRCS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRCS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                urgent[i] <= (cnt_d[i] == CNT_MAX);
            end
            if (accept_c) begin
                dst_val  <= 1'b1;
                dst_data <= sel_data_c;
            end else if (dst_rdy) begin
                dst_val  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_send_pkt_sched.sv
// Directed bench for send_pkt_sched: reset, priority, starvation, backpressure, withdrawal.
module tb_send_pkt_sched;

    logic        clk;
    logic        rst;
    logic [2:0]  src_val;
    logic [63:0] d [3];
    logic [191:0] src_data;
    logic [2:0]  src_rdy;
    logic        dst_val;
    logic [63:0] dst_data;
    logic        dst_rdy;
    logic [2:0]  urgent;

    int total;
    int passed;

    assign src_data = {d[2], d[1], d[0]};

    send_pkt_sched #(.NUM_SRCS(3), .DATA_W(64), .STARVE_LIMIT(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .src_val  (src_val),
        .src_data (src_data),
        .src_rdy  (src_rdy),
        .dst_val  (dst_val),
        .dst_data (dst_data),
        .dst_rdy  (dst_rdy),
        .urgent   (urgent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        src_val = 3'b000;
        @(negedge clk);
        rst     = 1'b1;
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        d[0]    = 64'h10;
        d[1]    = 64'h11;
        d[2]    = 64'h12;
        rst     = 1'b0;
        src_val = 3'b111;
        dst_rdy = 1'b1;

        // Reset holds everything quiet even with all sources requesting
        #12;
        chk("rst_dst_val", 64'(dst_val), 64'd0);
        chk("rst_src_rdy", 64'(src_rdy), 64'd0);
        chk("rst_urgent", 64'(urgent), 64'd0);
        chk("rst_dst_data", dst_data, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_src_rdy", 64'(src_rdy), 64'b001);
        step();
        chk("rel_dst_val", 64'(dst_val), 64'd1);
        chk("rel_dst_data", dst_data, 64'h10);

        // src0 beats src2 for 8 cycles, then src2 is promoted
        do_reset();
        src_val = 3'b101;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("pri_src_rdy", 64'(src_rdy), 64'b001);
            chk("pri_urgent", 64'(urgent), 64'd0);
            step();
            chk("pri_dst_val", 64'(dst_val), 64'd1);
            chk("pri_dst_data", dst_data, 64'h10);
        end
        chk("pri_urg_set", 64'(urgent), 64'b100);
        chk("pri_src2_rdy", 64'(src_rdy), 64'b100);
        step();
        chk("pri_src2_data", dst_data, 64'h12);
        chk("pri_src2_val", 64'(dst_val), 64'd1);
        chk("pri_urg_clr", 64'(urgent), 64'd0);
        chk("pri_resume", 64'(src_rdy), 64'b001);
        step();
        chk("pri_resume_data", dst_data, 64'h10);

        // Backpressure holds the slot and blocks all grants
        do_reset();
        d[0]    = 64'hA5;
        d[1]    = 64'hB1;
        src_val = 3'b001;
        step();
        chk("bp_load_data", dst_data, 64'hA5);
        dst_rdy = 1'b0;
        src_val = 3'b010;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_src_rdy", 64'(src_rdy), 64'd0);
            step();
            chk("bp_dst_val", 64'(dst_val), 64'd1);
            chk("bp_dst_data", dst_data, 64'hA5);
            chk("bp_urgent", 64'(urgent), 64'd0);
        end
        dst_rdy = 1'b1;
        #1;
        chk("bp_rel_src_rdy", 64'(src_rdy), 64'b010);
        step();
        chk("bp_rel_data", dst_data, 64'hB1);
        chk("bp_rel_val", 64'(dst_val), 64'd1);
        src_val = 3'b000;
        step();
        chk("bp_drain_val", 64'(dst_val), 64'd0);
        chk("bp_drain_hold", dst_data, 64'hB1);

        // Two sources starve together: lower index served first
        do_reset();
        d[0]    = 64'h10;
        d[1]    = 64'h11;
        src_val = 3'b111;
        repeat (8) step();
        chk("mu_urgent", 64'(urgent), 64'b110);
        chk("mu_rdy1", 64'(src_rdy), 64'b010);
        step();
        chk("mu_data1", dst_data, 64'h11);
        chk("mu_urgent2", 64'(urgent), 64'b100);
        chk("mu_rdy2", 64'(src_rdy), 64'b100);
        step();
        chk("mu_data2", dst_data, 64'h12);
        chk("mu_urgent0", 64'(urgent), 64'd0);
        chk("mu_rdy0", 64'(src_rdy), 64'b001);
        step();
        chk("mu_data0", dst_data, 64'h10);

        // Withdrawal resets the starvation count
        do_reset();
        src_val = 3'b101;
        repeat (5) step();
        src_val = 3'b001;
        step();
        src_val = 3'b101;
        repeat (7) step();
        chk("wd_not_urgent", 64'(urgent), 64'd0);
        step();
        chk("wd_urgent", 64'(urgent), 64'b100);

        // Asynchronous reset mid-stall drops the packet and starvation state
        do_reset();
        src_val = 3'b101;
        repeat (8) step();
        chk("mr_urg_pre", 64'(urgent), 64'b100);
        dst_rdy = 1'b0;
        #1;
        chk("mr_stall_rdy", 64'(src_rdy), 64'd0);
        step();
        chk("mr_stall_val", 64'(dst_val), 64'd1);
        chk("mr_stall_urg", 64'(urgent), 64'b100);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_dst_val", 64'(dst_val), 64'd0);
        chk("mr_urgent", 64'(urgent), 64'd0);
        chk("mr_dst_data", dst_data, 64'd0);
        chk("mr_src_rdy", 64'(src_rdy), 64'd0);
        @(negedge clk);
        rst     = 1'b1;
        dst_rdy = 1'b1;
        repeat (7) step();
        chk("mr_cnt_clr", 64'(urgent), 64'd0);
        step();
        chk("mr_cnt_full", 64'(urgent), 64'b100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
